// File: rtl/layer6_pkg.sv
// Shared definitions for the layer6 input sequencer: layer5 data width,
// grid geometry, beat count and the sequencer state encoding.

`ifndef LAYER5_OUTPUT_LENGTH
`define LAYER5_OUTPUT_LENGTH 16
`endif

package layer6_pkg;

  localparam int GRID_SIDE  = 5;
  localparam int BEAT_COUNT = GRID_SIDE * GRID_SIDE;

  // Row/column counters only need to reach GRID_SIDE-1.
  localparam int CNT_W = 3;
  localparam int IDX_W = 5;

  localparam logic [CNT_W-1:0] LAST_RC = CNT_W'(GRID_SIDE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Row-major beat position of a grid cell.
  function automatic logic [IDX_W-1:0] grid_index(input logic [CNT_W-1:0] row,
                                                  input logic [CNT_W-1:0] col);
    return IDX_W'(row) * IDX_W'(GRID_SIDE) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/layer6_input_sequencer.sv
// Streams the 5x5 layer5 result grid (both halves per position) as
// valid/ready beats. The single output register doubles as the skid stage:
// a new read is issued only when that register is empty or being drained.

module layer6_input_sequencer
  import layer6_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [`LAYER5_OUTPUT_LENGTH-1:0]   layer5_result_output1,
  input  logic [`LAYER5_OUTPUT_LENGTH-1:0]   layer5_result_output2,
  output logic [15:0]                        read_row_addr,
  output logic [15:0]                        read_col_addr,
  output logic                               layer5_result_read_signal1,
  output logic                               layer5_result_read_signal2,
  output logic [`LAYER5_OUTPUT_LENGTH-1:0]   out_data1,
  output logic [`LAYER5_OUTPUT_LENGTH-1:0]   out_data2,
  output logic [IDX_W-1:0]                   out_index,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done
);

  seq_state_t       state;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             rd;
  logic             last_pos;

  // A read may be issued whenever the output register is free this cycle.
  assign rd       = (state == READ) && (!out_valid || out_ready);
  assign last_pos = (row == LAST_RC) && (col == LAST_RC);

  assign layer5_result_read_signal1 = rd;
  assign layer5_result_read_signal2 = rd;

  // Addresses are zero in IDLE and otherwise track (and hold) the counters.
  assign read_row_addr = (state == IDLE) ? 16'd0 : {{(16-CNT_W){1'b0}}, row};
  assign read_col_addr = (state == IDLE) ? 16'd0 : {{(16-CNT_W){1'b0}}, col};

  // Sequencer FSM, scan counters and the registered beat outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every output register is cleared asynchronously so an abort
      // mid-scan drops the beat and the handshake immediately.
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        READ: begin
          // In READ a free register always means a read, so out_valid only
          // ever stays set or is refreshed here.
          if (rd) begin
            out_data1 <= layer5_result_output1;
            out_data2 <= layer5_result_output2;
            out_index <= grid_index(row, col);
            out_valid <= 1'b1;
            if (last_pos) begin
              state <= DRAIN;
            end else if (col == LAST_RC) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
